// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the inverse-arithmetic unit.
//   state_t  : controller states IDLE / CALC / DONE
//   OPND_W   : operand / result width (16)
//   PROD_W   : dividend width (32)
//   ITER     : restoring-divide iterations, one quotient bit each (16)
//   CNT_W    : width of the iteration counter
//   QUOT_SAT : quotient returned on divide-by-zero or overflow
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int OPND_W = 16;
    localparam int PROD_W = 32;
    localparam int ITER   = 16;
    localparam int CNT_W  = $clog2(ITER);

    localparam logic [OPND_W-1:0] QUOT_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/inverse_arith_if.sv
// ---------------------------------------------------------------------------
// inverse_arith_if
// Request / result bundle of the inverse-arithmetic unit.
//   start       : request pulse (master -> slave)
//   sum         : sum to invert (master -> slave)
//   product     : dividend (master -> slave)
//   b           : known operand, subtrahend / divisor (master -> slave)
//   diff        : sum - b (slave -> master)
//   quotient    : product / b (slave -> master)
//   remainder   : product mod b (slave -> master)
//   busy        : unit is not idle (slave -> master)
//   done        : one-cycle result-valid pulse (slave -> master)
//   div_by_zero : b was zero at capture (slave -> master)
//   overflow    : true quotient wider than 16 bits (slave -> master)
// ---------------------------------------------------------------------------
interface inverse_arith_if;
    import arith_pkg::*;

    logic                start;
    logic [OPND_W-1:0]   sum;
    logic [PROD_W-1:0]   product;
    logic [OPND_W-1:0]   b;
    logic [OPND_W-1:0]   diff;
    logic [OPND_W-1:0]   quotient;
    logic [OPND_W-1:0]   remainder;
    logic                busy;
    logic                done;
    logic                div_by_zero;
    logic                overflow;

    modport master (
        output start, sum, product, b,
        input  diff, quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, sum, product, b,
        output diff, quotient, remainder, busy, done, div_by_zero, overflow
    );

endinterface

// File: rtl/inverse_arith_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, keep the difference when
// it is non-negative and report that as the quotient bit.
//   i_prem    : 17-bit partial remainder from the previous step
//   i_bit     : next dividend bit (MSB first)
//   i_divisor : divisor
//   o_prem    : updated 17-bit partial remainder
//   o_qbit    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
    import arith_pkg::*;
(
    input  logic [OPND_W:0]   i_prem,
    input  logic              i_bit,
    input  logic [OPND_W-1:0] i_divisor,
    output logic [OPND_W:0]   o_prem,
    output logic              o_qbit
);

    logic [OPND_W:0]   w_shift;
    logic [OPND_W+1:0] w_trial;

    // The held remainder is always below the divisor, so its low 16 bits plus
    // the new dividend bit form the full 17-bit shifted value.
    assign w_shift = {i_prem[OPND_W-1:0], i_bit};

    // One extra bit so the sign of the trial subtraction is visible.
    assign w_trial = {1'b0, w_shift} - {2'b00, i_divisor};

    // i_prem[OPND_W] is never set while the remainder stays below the
    // divisor; if it were, the shifted value would certainly exceed it.
    assign o_qbit = i_prem[OPND_W] | ~w_trial[OPND_W+1];
    assign o_prem = o_qbit ? w_trial[OPND_W:0] : w_shift;

endmodule

// File: rtl/inverse_arith.sv
// ---------------------------------------------------------------------------
// inverse_arith
// Recovers operand a from a registered sum (a = sum - b) and from a registered
// product (a = product / b, 16-iteration restoring divide, one bit per cycle).
// Divide-by-zero and quotient overflow are detected at capture and finish in
// a single cycle with a saturated quotient.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : inverse_arith_if.slave (start/sum/product/b in; diff/quotient/
//         remainder/busy/done/div_by_zero/overflow out)
// Build option: INVERSE_ARITH_REMAINDER_EN -- when defined the remainder
// output is registered and driven; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module inverse_arith
    import arith_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    inverse_arith_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [OPND_W-1:0]   r_div;
    logic [OPND_W-1:0]   r_dlo;     // low dividend half, shifted out MSB first
    logic [OPND_W:0]     r_prem;    // 17-bit partial remainder
    logic [OPND_W-2:0]   r_qsh;     // quotient bits gathered so far
    logic [OPND_W-1:0]   r_diff;
    logic [OPND_W-1:0]   r_quot;
    logic                r_dbz;
    logic                r_ovf;
`ifdef INVERSE_ARITH_REMAINDER_EN
    logic [OPND_W-1:0]   r_rem;
`endif

    logic                w_capture;
    logic                w_zero;
    logic                w_big;
    logic                w_last;
    logic [OPND_W:0]     w_prem;
    logic                w_qbit;

    assign w_capture = (r_state == IDLE) && bus.start;
    assign w_zero    = (bus.b == '0);
    // With the high dividend half at or above the divisor the quotient
    // cannot fit in 16 bits.
    assign w_big     = (bus.product[PROD_W-1:OPND_W] >= bus.b);
    assign w_last    = (r_cnt == CNT_W'(ITER - 1));

    div_step u_div_step (
        .i_prem    (r_prem),
        .i_bit     (r_dlo[OPND_W-1]),
        .i_divisor (r_div),
        .o_prem    (w_prem),
        .o_qbit    (w_qbit)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_zero || w_big) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_div  <= '0;
            r_dlo  <= '0;
            r_prem <= '0;
            r_qsh  <= '0;
            r_diff <= '0;
            r_quot <= '0;
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
`ifdef INVERSE_ARITH_REMAINDER_EN
            r_rem  <= '0;
`endif
        end else begin
            if (w_capture) begin
                r_diff <= bus.sum - bus.b;
                r_dbz  <= 1'b0;
                r_ovf  <= 1'b0;
                r_div  <= bus.b;
                r_dlo  <= bus.product[OPND_W-1:0];
                r_prem <= {1'b0, bus.product[PROD_W-1:OPND_W]};
                r_qsh  <= '0;
                r_cnt  <= '0;
                if (w_zero) begin
                    r_quot <= QUOT_SAT;
                    r_dbz  <= 1'b1;
`ifdef INVERSE_ARITH_REMAINDER_EN
                    r_rem  <= bus.product[OPND_W-1:0];
`endif
                end else if (w_big) begin
                    r_quot <= QUOT_SAT;
                    r_ovf  <= 1'b1;
`ifdef INVERSE_ARITH_REMAINDER_EN
                    r_rem  <= '0;
`endif
                end
            end else if (r_state == CALC) begin
                r_prem <= w_prem;
                r_dlo  <= {r_dlo[OPND_W-2:0], 1'b0};
                r_qsh  <= {r_qsh[OPND_W-3:0], w_qbit};
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_quot <= {r_qsh, w_qbit};
`ifdef INVERSE_ARITH_REMAINDER_EN
                    r_rem  <= w_prem[OPND_W-1:0];
`endif
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.diff        = r_diff;
    assign bus.quotient    = r_quot;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;
`ifdef INVERSE_ARITH_REMAINDER_EN
    assign bus.remainder   = r_rem;
`else
    assign bus.remainder   = '0;
`endif

endmodule

// File: tb/tb_inverse_arith.sv
// ---------------------------------------------------------------------------
// tb_inverse_arith
// Directed and randomized transactions against a plain-arithmetic model of
// the inverse-arithmetic unit: result values, flags, done latency, ignored
// restarts and reset in the middle of a divide.
// ---------------------------------------------------------------------------
module tb_inverse_arith;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inverse_arith_if bus_if ();

    inverse_arith dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] diff;
        logic [15:0] quot;
        logic [15:0] rem;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    // Reference: a = sum - b, a = product / b with saturation rules.
    function automatic exp_t model(input logic [15:0] s, input logic [31:0] p,
                                   input logic [15:0] bb);
        exp_t        e;
        logic [31:0] q;
        logic [31:0] r;
        e.diff = 16'(s - bb);
        e.dbz  = 1'b0;
        e.ovf  = 1'b0;
        if (bb == 16'd0) begin
            e.quot = 16'hFFFF;
            e.rem  = p[15:0];
            e.dbz  = 1'b1;
            e.lat  = 1;
        end else begin
            q = p / {16'd0, bb};
            r = p % {16'd0, bb};
            if (q > 32'h0000_FFFF) begin
                e.quot = 16'hFFFF;
                e.rem  = 16'd0;
                e.ovf  = 1'b1;
                e.lat  = 1;
            end else begin
                e.quot = q[15:0];
                e.rem  = r[15:0];
                e.lat  = 17;
            end
        end
`ifndef INVERSE_ARITH_REMAINDER_EN
        e.rem = 16'd0;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input exp_t e);
        chk({tag, ".diff"},      32'(bus_if.diff),        32'(e.diff));
        chk({tag, ".quotient"},  32'(bus_if.quotient),    32'(e.quot));
        chk({tag, ".remainder"}, 32'(bus_if.remainder),   32'(e.rem));
        chk({tag, ".dbz"},       32'(bus_if.div_by_zero), 32'(e.dbz));
        chk({tag, ".ovf"},       32'(bus_if.overflow),    32'(e.ovf));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".diff"},      32'(bus_if.diff),        32'd0);
        chk({tag, ".quotient"},  32'(bus_if.quotient),    32'd0);
        chk({tag, ".remainder"}, 32'(bus_if.remainder),   32'd0);
        chk({tag, ".dbz"},       32'(bus_if.div_by_zero), 32'd0);
        chk({tag, ".ovf"},       32'(bus_if.overflow),    32'd0);
        chk({tag, ".busy"},      32'(bus_if.busy),        32'd0);
        chk({tag, ".done"},      32'(bus_if.done),        32'd0);
    endtask

    // Called #1 after a clock edge while the unit is idle; returns #1 after
    // the edge that leaves DONE, so the next call starts back-to-back.
    task automatic run_op(input string tag, input logic [15:0] s,
                          input logic [31:0] p, input logic [15:0] bb);
        exp_t e;
        int   n;
        e = model(s, p, bb);
        bus_if.start   = 1'b1;
        bus_if.sum     = s;
        bus_if.product = p;
        bus_if.b       = bb;
        @(posedge clk); #1;
        bus_if.start   = 1'b0;
        bus_if.sum     = 16'($urandom);
        bus_if.product = $urandom;
        bus_if.b       = 16'($urandom);
        chk({tag, ".busy"}, 32'(bus_if.busy), 32'd1);
        n = 1;
        while (bus_if.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(e.lat));
        chk_result(tag, e);
        @(posedge clk); #1;
        chk({tag, ".done_end"}, 32'(bus_if.done), 32'd0);
        chk({tag, ".busy_end"}, 32'(bus_if.busy), 32'd0);
        $display("op %s sum=0x%h product=0x%h b=0x%h -> diff=0x%h q=0x%h r=0x%h dbz=%0d ovf=%0d lat=%0d",
                 tag, s, p, bb, bus_if.diff, bus_if.quotient, bus_if.remainder,
                 bus_if.div_by_zero, bus_if.overflow, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int          n;
        int          extra;
        logic [15:0] rs;
        logic [15:0] rb;
        logic [31:0] rp;

        rst            = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.sum     = '0;
        bus_if.product = '0;
        bus_if.b       = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op("basic_294_7",   16'd49,     32'd294,          16'd7);
        run_op("rem_300_7",     16'd0,      32'd300,          16'd7);
        run_op("neg_diff",      16'd5,      32'd700,          16'd7);
        run_op("div_by_zero",   16'h1234,   32'h0001_2345,    16'd0);
        run_op("overflow",      16'h00FF,   32'h0007_0000,    16'd7);
        run_op("max_quot",      16'd1,      32'h0006_FFFF,    16'd7);
        run_op("divisor_ffff",  16'hFFFF,   32'hFFFE_FFFF,    16'hFFFF);
        run_op("divisor_one",   16'd3,      32'h0000_FFFF,    16'd1);

        // Randomized cases
        for (int i = 0; i < 24; i++) begin
            rs = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 3) rb = 16'd0;
            rp = $urandom;
            if ((i % 3 != 2) && (rb != 16'd0)) rp = rp % {rb, 16'h0000};
            run_op("random", rs, rp, rb);
        end

        // Restart pulsed in CALC cycle 5 with different operands is ignored
        e = model(16'd1000, 32'd123456, 16'd321);
        bus_if.start   = 1'b1;
        bus_if.sum     = 16'd1000;
        bus_if.product = 32'd123456;
        bus_if.b       = 16'd321;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        n = 1;
        while (bus_if.done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                bus_if.start   = 1'b1;
                bus_if.sum     = 16'($urandom);
                bus_if.product = $urandom;
                bus_if.b       = 16'd0;
            end else begin
                bus_if.start = 1'b0;
            end
        end
        chk("repulse.latency", 32'(n), 32'(e.lat));
        chk_result("repulse", e);
        extra = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) extra++;
        end
        chk("repulse.extra_done", 32'(extra), 32'd0);
        $display("op repulse q=0x%h r=0x%h lat=%0d extra_done=%0d",
                 bus_if.quotient, bus_if.remainder, n, extra);

        // Reset in the middle of CALC cycle 8
        bus_if.start   = 1'b1;
        bus_if.sum     = 16'h0BAD;
        bus_if.product = 32'd5000;
        bus_if.b       = 16'd3;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (7) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) extra++;
        end
        chk("mid_reset.no_done", 32'(extra), 32'd0);
        chk("mid_reset.idle", 32'(bus_if.busy), 32'd0);
        $display("op mid_reset done_pulses=%0d", extra);
        run_op("after_reset", 16'd7, 32'd100, 16'd10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inverse_arith.md
INVERSE_ARITH -- requirements
Module: inverse_arith

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous and active-high.
REQ-003 SHALL have ports: start  in  1  request pulse, sampled only in IDLE.
REQ-004 SHALL have ports: sum  in  16  registered sum to invert.
REQ-005 SHALL have ports: product  in  32  registered product to invert (dividend).
REQ-006 SHALL have ports: b  in  16  known operand (subtrahend/divisor).
REQ-007 SHALL have ports: diff  out  16  recovered a from sum, i.e. sum - b.
REQ-008 SHALL have ports: quotient  out  16  recovered a from product, i.e. product / b.
REQ-009 SHALL have ports: remainder  out  16  product mod b.
REQ-010 SHALL have ports: busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have ports: done  out  1  one-cycle result-valid pulse.
REQ-012 SHALL have ports: div_by_zero  out  1  b was 0 at capture.
REQ-013 SHALL have ports: overflow  out  1  true quotient exceeds 16 bits.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE.
REQ-015 SHALL capture sum, product and b on the edge where start=1 in IDLE; later input changes SHALL NOT affect the result.
REQ-016 SHALL register diff = (sum - b) mod 2^16 on that capture edge; diff SHALL be held until the next capture.
REQ-017 SHALL, when b=0, go IDLE->DONE and set quotient=16'hFFFF, remainder=product[15:0] and div_by_zero=1.
REQ-018 SHALL, when b!=0 and product[31:16] >= b, go IDLE->DONE and set quotient=16'hFFFF, remainder=0 and overflow=1.
REQ-019 SHALL otherwise go IDLE->CALC and run a restoring divide of 16 iterations, one quotient bit per cycle, MSB first.
REQ-020 SHALL use a 17-bit partial remainder so that the subtract never truncates.
REQ-021 SHALL leave CALC for DONE after exactly 16 CALC cycles; done SHALL rise 17 cycles after the capture edge.
REQ-022 SHALL raise done exactly while in DONE, which lasts one cycle, then return to IDLE.
REQ-023 SHALL ignore start while busy=1; no recapture and no queuing.
REQ-024 SHALL accept start in the cycle after DONE (back-to-back operation).
REQ-025 SHALL hold quotient, remainder, div_by_zero and overflow from DONE until the next capture.
REQ-026 SHALL clear div_by_zero and overflow on each capture.

Reset
REQ-027 SHALL, on rst=1 and independent of clk, force state=IDLE and clear every output to 0.
REQ-028 SHALL, when rst asserts mid-CALC, abandon the operation with no done pulse; the first start after release SHALL begin a fresh operation.

Configuration
REQ-029 SHALL use the macro INVERSE_ARITH_REMAINDER_EN.
REQ-030 SHALL, when INVERSE_ARITH_REMAINDER_EN is defined, drive remainder per REQ-009, REQ-017 and REQ-018.
REQ-031 SHALL, when INVERSE_ARITH_REMAINDER_EN is undefined, keep the remainder port and tie it to 0; the final remainder SHALL NOT be registered; quotient, done timing and flags SHALL be unchanged.

Structure
REQ-032 SHALL take from shared package arith_pkg: state enum (IDLE, CALC, DONE), OPND_W=16, PROD_W=32, ITER=16, QUOT_SAT=16'hFFFF.
REQ-033 SHALL place the datapath in one sub-module, div_step, a combinational single restoring step (shift, trial subtract, quotient bit); control and registers SHALL stay in inverse_arith.

Verification
REQ-034 SHALL cover: product=294, b=7, sum=49 -> quotient=42, remainder=0, diff=42, done 17 cycles after start.
REQ-035 SHALL cover: product=300, b=7 -> quotient=42, remainder=6; with the macro undefined -> remainder=0.
REQ-036 SHALL cover: sum=5, b=7 -> diff=16'hFFFE; b=0, product=32'h0001_2345 -> div_by_zero=1, quotient=16'hFFFF, remainder=16'h2345, done 1 cycle after start.
REQ-037 SHALL cover: product=32'h0007_0000, b=7 -> overflow=1, quotient=16'hFFFF, done 1 cycle after start.
REQ-038 SHALL cover: start re-pulsed at CALC cycle 5 with new operands -> ignored, original result returned, single done.
REQ-039 SHALL cover: rst asserted at CALC cycle 8, mid-clock -> outputs 0 immediately, no done; next start with product=100, b=10 -> quotient=10.
